// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request generator with prioritised
// redirects, alignment rejection, a stall/trap watchdog and a handshake counter.
module pc_fetch_unit #(
  parameter int unsigned            width        = 32,
  parameter logic [width-1:0]       reset_vector = 32'h0000_0000,
  parameter logic [width-1:0]       trap_vector  = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             trap,
  input  logic             mret,
  input  logic [width-1:0] mepc,
  input  logic             jump,
  input  logic [width-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [width-1:0] branch_target,
  input  logic             imem_req_ready,
  output logic             imem_req_valid,
  output logic [width-1:0] imem_addr,
  output logic [1:0]       next_sel,
  output logic             misaligned,
  output logic [31:0]      fetch_count
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JB   = 2'b01;
  localparam logic [1:0] SEL_MRET = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] pc_q, pc_d;
  logic [31:0]      fetch_count_q, fetch_count_d;
  logic [3:0]       stall_cnt_q, stall_cnt_d;
  logic             misaligned_q, misaligned_d;

  logic             handshake;
  logic             redir_req;
  logic             redir_chk;
  logic             redir_bad;
  logic [1:0]       redir_sel;
  logic [width-1:0] redir_target;
  logic [width-1:0] jump_target_clr;

  // Redirect arbitration: RUN honours every source, HALT listens only to mret.
  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    jump_target_clr = {jump_target[width-1:1], 1'b0};
    redir_req       = 1'b0;
    redir_chk       = 1'b0;
    redir_sel       = SEL_SEQ;
    redir_target    = pc_q;
    if (state_q == ST_RUN) begin
      if (trap) begin
        redir_req    = 1'b1;
        redir_sel    = SEL_TRAP;
        redir_target = trap_vector;
      end else if (mret) begin
        redir_req    = 1'b1;
        redir_chk    = 1'b1;
        redir_sel    = SEL_MRET;
        redir_target = mepc;
      end else if (jump) begin
        redir_req    = 1'b1;
        redir_chk    = 1'b1;
        redir_sel    = SEL_JB;
        redir_target = jump_target_clr;
      end else if (branch_taken) begin
        redir_req    = 1'b1;
        redir_chk    = 1'b1;
        redir_sel    = SEL_JB;
        redir_target = branch_target;
      end
    end else if (state_q == ST_HALT && mret) begin
      redir_req    = 1'b1;
      redir_chk    = 1'b1;
      redir_sel    = SEL_MRET;
      redir_target = mepc;
    end
    redir_bad = redir_req && redir_chk && redir_target[1];
  end

  always_comb begin
    imem_req_valid = (state_q == ST_RUN) && !stall && !rst;
    handshake      = imem_req_valid && imem_req_ready;
    next_sel       = (redir_req && !redir_bad && !rst) ? redir_sel : SEL_SEQ;
    imem_addr      = pc_q;
    misaligned     = misaligned_q;
    fetch_count    = fetch_count_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stall_cnt_d   = 4'd0;
    misaligned_d  = redir_bad;
    fetch_count_d = fetch_count_q + {31'd0, handshake};
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redir_req && !redir_bad) begin
          pc_d = redir_target;
        end else if (handshake && !redir_bad) begin
          pc_d = pc_q + width'(4);
        end
        // Watchdog: a trap held off by stall for 16 straight cycles parks the unit.
        if (stall && trap && !mret) begin
          if (stall_cnt_q == 4'hF) begin
            state_d = ST_HALT;
          end else begin
            stall_cnt_d = stall_cnt_q + 4'd1;
          end
        end
      end
      ST_HALT: begin
        if (redir_req && !redir_bad) begin
          pc_d    = redir_target;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= reset_vector;
      fetch_count_q <= 32'd0;
      stall_cnt_q   <= 4'd0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      stall_cnt_q   <= stall_cnt_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs change and outputs are sampled
// around the falling edge, with hand-computed expectations per scenario.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        trap;
  logic        mret;
  logic [31:0] mepc;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req_ready;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [1:0]  next_sel;
  logic        misaligned;
  logic [31:0] fetch_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .width        (32),
    .reset_vector (32'h0000_0000),
    .trap_vector  (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .trap           (trap),
    .mret           (mret),
    .mepc           (mepc),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req_ready (imem_req_ready),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .next_sel       (next_sel),
    .misaligned     (misaligned),
    .fetch_count    (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 0; trap = 0; mret = 0; mepc = '0; jump = 0; jump_target = '0;
    branch_taken = 0; branch_target = '0; imem_req_ready = 0;
  endtask

  // Leaves the DUT in RUN at a falling edge with PC=0, count=0, all inputs idle.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    imem_req_ready = 1;
    rst = 1;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got=%b exp=0", imem_req_valid); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
    vec_cnt++; if (misaligned !== 1'b0) begin err_cnt++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid_hi got=%b exp=0", imem_req_valid); end
    rst = 0;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL boot_valid got=%b exp=0", imem_req_valid); end
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b1) begin err_cnt++; $display("FAIL run_valid got=%b exp=1", imem_req_valid); end
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL run_addr got=%h exp=0", imem_addr); end
    imem_req_ready = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    imem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++; if (imem_addr !== 32'(4 * i)) begin err_cnt++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
      vec_cnt++; if (next_sel !== 2'b00) begin err_cnt++; $display("FAIL seq_sel%0d got=%b exp=00", i, next_sel); end
      tick();
    end
    vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
    vec_cnt++; if (imem_addr !== 32'h10) begin err_cnt++; $display("FAIL seq_addr_end got=%h exp=10", imem_addr); end
    imem_req_ready = 0;
  endtask

  task automatic test_ready_hold();
    do_reset();
    imem_req_ready = 1;
    tick();
    tick();
    imem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++; if (imem_addr !== 32'h8) begin err_cnt++; $display("FAIL hold_addr%0d got=%h exp=8", i, imem_addr); end
      vec_cnt++; if (imem_req_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_valid%0d got=%b exp=1", i, imem_req_valid); end
      tick();
    end
    vec_cnt++; if (fetch_count !== 32'd2) begin err_cnt++; $display("FAIL hold_count got=%0d exp=2", fetch_count); end
    imem_req_ready = 1;
    tick();
    vec_cnt++; if (imem_addr !== 32'hC) begin err_cnt++; $display("FAIL hold_release got=%h exp=c", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'd3) begin err_cnt++; $display("FAIL hold_count2 got=%0d exp=3", fetch_count); end
    imem_req_ready = 0;
  endtask

  // Continues from PC=0xC, count=3, ready low.
  task automatic test_redirect_priority();
    trap = 1; jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
    #1;
    vec_cnt++; if (next_sel !== 2'b11) begin err_cnt++; $display("FAIL prio_trap_sel got=%b exp=11", next_sel); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h100) begin err_cnt++; $display("FAIL prio_trap_pc got=%h exp=100", imem_addr); end
    trap = 0; branch_taken = 0;
    #1;
    vec_cnt++; if (next_sel !== 2'b01) begin err_cnt++; $display("FAIL prio_jump_sel got=%b exp=01", next_sel); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h200) begin err_cnt++; $display("FAIL prio_jump_pc got=%h exp=200", imem_addr); end
    mret = 1; mepc = 32'h400;
    #1;
    vec_cnt++; if (next_sel !== 2'b10) begin err_cnt++; $display("FAIL prio_mret_sel got=%b exp=10", next_sel); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h400) begin err_cnt++; $display("FAIL prio_mret_pc got=%h exp=400", imem_addr); end
    mret = 0; jump = 0; stall = 1; branch_taken = 1;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_valid got=%b exp=0", imem_req_valid); end
    vec_cnt++; if (next_sel !== 2'b01) begin err_cnt++; $display("FAIL br_sel got=%b exp=01", next_sel); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h300) begin err_cnt++; $display("FAIL br_stall_pc got=%h exp=300", imem_addr); end
    stall = 0; branch_taken = 0;
  endtask

  // Continues from PC=0x300, ready low.
  task automatic test_misaligned();
    jump = 1; jump_target = 32'h206;
    #1;
    vec_cnt++; if (next_sel !== 2'b00) begin err_cnt++; $display("FAIL mis_sel got=%b exp=00", next_sel); end
    vec_cnt++; if (misaligned !== 1'b0) begin err_cnt++; $display("FAIL mis_pre got=%b exp=0", misaligned); end
    tick();
    jump = 0;
    vec_cnt++; if (misaligned !== 1'b1) begin err_cnt++; $display("FAIL mis_pulse got=%b exp=1", misaligned); end
    vec_cnt++; if (imem_addr !== 32'h300) begin err_cnt++; $display("FAIL mis_pc got=%h exp=300", imem_addr); end
    tick();
    vec_cnt++; if (misaligned !== 1'b0) begin err_cnt++; $display("FAIL mis_end got=%b exp=0", misaligned); end
    jump = 1; jump_target = 32'h205;
    #1;
    vec_cnt++; if (next_sel !== 2'b01) begin err_cnt++; $display("FAIL jalr_sel got=%b exp=01", next_sel); end
    tick();
    jump = 0;
    vec_cnt++; if (imem_addr !== 32'h204) begin err_cnt++; $display("FAIL jalr_pc got=%h exp=204", imem_addr); end
    vec_cnt++; if (misaligned !== 1'b0) begin err_cnt++; $display("FAIL jalr_mis got=%b exp=0", misaligned); end
  endtask

  // Continues from PC=0x204, count=3.
  task automatic test_trap_handshake();
    imem_req_ready = 1; trap = 1;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b1) begin err_cnt++; $display("FAIL th_valid got=%b exp=1", imem_req_valid); end
    tick();
    trap = 0; imem_req_ready = 0;
    vec_cnt++; if (imem_addr !== 32'h100) begin err_cnt++; $display("FAIL th_pc got=%h exp=100", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'd4) begin err_cnt++; $display("FAIL th_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_count_wrap();
    imem_req_ready = 0;
    dut.fetch_count_q = 32'hFFFF_FFFE;
    imem_req_ready = 1;
    tick();
    vec_cnt++; if (fetch_count !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL wrap_pre got=%h exp=ffffffff", fetch_count); end
    tick();
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL wrap_zero got=%h exp=0", fetch_count); end
    imem_req_ready = 0;
  endtask

  task automatic test_watchdog();
    do_reset();
    stall = 1; trap = 1;
    repeat (15) tick();
    trap = 0;
    tick();
    trap = 1;
    repeat (15) tick();
    stall = 0; trap = 0;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b1) begin err_cnt++; $display("FAIL wd_not_yet got=%b exp=1", imem_req_valid); end
    stall = 1; trap = 1;
    repeat (16) tick();
    stall = 0; trap = 0; imem_req_ready = 1;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL wd_halt_valid got=%b exp=0", imem_req_valid); end
    vec_cnt++; if (imem_addr !== 32'h100) begin err_cnt++; $display("FAIL wd_halt_pc got=%h exp=100", imem_addr); end
    jump = 1; jump_target = 32'h200;
    #1;
    vec_cnt++; if (next_sel !== 2'b00) begin err_cnt++; $display("FAIL wd_jump_sel got=%b exp=00", next_sel); end
    tick();
    jump = 0;
    vec_cnt++; if (imem_addr !== 32'h100) begin err_cnt++; $display("FAIL wd_jump_pc got=%h exp=100", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'd0) begin err_cnt++; $display("FAIL wd_count got=%0d exp=0", fetch_count); end
    mret = 1; mepc = 32'h80;
    #1;
    vec_cnt++; if (next_sel !== 2'b10) begin err_cnt++; $display("FAIL wd_mret_sel got=%b exp=10", next_sel); end
    tick();
    mret = 0;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b1) begin err_cnt++; $display("FAIL wd_resume_valid got=%b exp=1", imem_req_valid); end
    vec_cnt++; if (imem_addr !== 32'h80) begin err_cnt++; $display("FAIL wd_resume_pc got=%h exp=80", imem_addr); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h84) begin err_cnt++; $display("FAIL wd_next_pc got=%h exp=84", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'd1) begin err_cnt++; $display("FAIL wd_count2 got=%0d exp=1", fetch_count); end
    imem_req_ready = 0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    stall = 1; trap = 1;
    repeat (3) tick();
    rst = 1; stall = 0;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rms_rst_valid got=%b exp=0", imem_req_valid); end
    vec_cnt++; if (next_sel !== 2'b00) begin err_cnt++; $display("FAIL rms_rst_sel got=%b exp=00", next_sel); end
    tick();
    rst = 0; trap = 0; imem_req_ready = 1;
    #1;
    vec_cnt++; if (imem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL rms_boot_valid got=%b exp=0", imem_req_valid); end
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rms_boot_pc got=%h exp=0", imem_addr); end
    vec_cnt++; if (fetch_count !== 32'h0) begin err_cnt++; $display("FAIL rms_count got=%0d exp=0", fetch_count); end
    tick();
    vec_cnt++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rms_fetch valid=%b addr=%h exp valid=1 addr=0", imem_req_valid, imem_addr); end
    tick();
    vec_cnt++; if (imem_addr !== 32'h4) begin err_cnt++; $display("FAIL rms_next got=%h exp=4", imem_addr); end
    imem_req_ready = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ready_hold();
    test_redirect_priority();
    test_misaligned();
    test_trap_handshake();
    test_count_wrap();
    test_watchdog();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
